// File: rtl/divclk_prg.sv
// Programmable cascaded clock-enable divider: NSTG stages, each dividing its
// upstream tick by R_k+1, with shadowed ratios, one-shot mode and a scan force.
module divclk_prg_stg #(
    parameter int             DW    = 8,
    parameter logic [DW-1:0]  RST_R = '0
) (
    input  logic          mclk,
    input  logic          srstz,
    input  logic          atpg_en,
    input  logic          run,
    input  logic          sclr,
    input  logic          upd,
    input  logic [DW-1:0] rin,
    input  logic          adv,
    input  logic          fup,
    output logic          tick,
    output logic          ftick,
    output logic          sqr
);
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rat_q, rat_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          wrap;

    // >= rather than == keeps the counter bounded even if a ratio shrinks while idle
    assign wrap  = (cnt_q >= rat_q);
    assign tick  = atpg_en | (adv & wrap);
    assign ftick = fup & wrap;
    assign sqr   = (rat_q == '0) || (cnt_q <= (rat_q >> 1));

    always_comb begin
        cnt_d = cnt_q;
        rat_d = rat_q;
        sh_d  = sh_q;
        if (sclr) begin
            cnt_d = '0;
        end else begin
            if (upd) sh_d = rin;
            if (adv) cnt_d = wrap ? '0 : cnt_q + 1'b1;
            // a load coinciding with a wrap takes effect at that very wrap
            if (tick || !run) rat_d = upd ? rin : sh_q;
        end
    end

    always_ff @(posedge mclk or negedge srstz) begin
        if (!srstz) begin
            cnt_q <= '0;
            rat_q <= RST_R;
            sh_q  <= RST_R;
        end else begin
            cnt_q <= cnt_d;
            rat_q <= rat_d;
            sh_q  <= sh_d;
        end
    end
endmodule

module divclk_prg #(
    parameter int                  NSTG      = 5,
    parameter int                  DW        = 8,
    parameter logic [NSTG*DW-1:0]  RST_RATIO = 40'h63_01_04_01_0B
) (
    input  logic                 mclk,
    input  logic                 srstz,
    input  logic                 atpg_en,
    input  logic                 div_en,
    input  logic                 div_sclr,
    input  logic                 oneshot,
    input  logic [NSTG*DW-1:0]   ratio_in,
    input  logic                 ratio_upd,
    output logic [NSTG-1:0]      tick,
    output logic [NSTG-1:0]      sqr,
    output logic                 done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            run, fup0;
    logic [NSTG-1:0] ftick;

    assign run  = (state_q == S_RUN);
    assign fup0 = div_en & run;
    assign done = (state_q == S_DONE);

    // ftick is the chain without the scan force; the FSM only sees real ticks
    genvar k;
    for (k = 0; k < NSTG; k++) begin : g_stg
        logic adv_k, fup_k;
        if (k == 0) begin : g_head
            assign adv_k = atpg_en | fup0;
            assign fup_k = fup0;
        end else begin : g_link
            assign adv_k = tick[k-1];
            assign fup_k = ftick[k-1];
        end
        divclk_prg_stg #(.DW(DW), .RST_R(RST_RATIO[k*DW +: DW])) u_stg (
            .mclk    (mclk),
            .srstz   (srstz),
            .atpg_en (atpg_en),
            .run     (run),
            .sclr    (div_sclr),
            .upd     (ratio_upd),
            .rin     (ratio_in[k*DW +: DW]),
            .adv     (adv_k),
            .fup     (fup_k),
            .tick    (tick[k]),
            .ftick   (ftick[k]),
            .sqr     (sqr[k])
        );
    end

    always_comb begin
        state_d = state_q;
        if (div_sclr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (div_en) state_d = S_RUN;
                S_RUN: begin
                    if (!div_en)                            state_d = S_IDLE;
                    else if (oneshot && ftick[NSTG-1])      state_d = S_DONE;
                end
                S_DONE:  if (!div_en) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge srstz) begin
        if (!srstz) state_q <= S_IDLE;
        else        state_q <= state_d;
    end
endmodule
